// File: rtl/pipe_pkg.sv
// pipe_pkg -- shared pipeline definitions.
//   ex_mem_payload_t : EX/MEM bundle carried through the pipeline stages
//   WB_* constants   : write-back source select encodings
//   skid_state_t     : state encoding of the skid stage (equals occupancy)
//   EX_MEM_W         : payload width derived from the struct
package pipe_pkg;

    localparam logic [1:0] WB_ALU  = 2'd0;
    localparam logic [1:0] WB_LOAD = 2'd1;
    localparam logic [1:0] WB_PC4  = 2'd2;

    typedef struct packed {
        logic [31:0] alu_result;
        logic [31:0] write_data;
        logic [4:0]  rd_address;
        logic        data_write_en;
        logic        reg_write;
        logic [1:0]  wb_sel;
        logic [31:0] pc_plus_four;
    } ex_mem_payload_t;

    localparam int EX_MEM_W = $bits(ex_mem_payload_t);

    // Encoding doubles as the occupancy count.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } skid_state_t;

endpackage

// File: rtl/pipe_skid_stage.sv
// pipe_skid_stage -- two-entry skid buffer with fully registered handshake.
//   clk, resetn     : clock, synchronous active-low reset
//   flush           : synchronous kill of all held entries (beats transfers)
//   in_valid/in_ready/in_data    : upstream handshake; in_ready is registered
//   out_valid/out_ready/out_data : downstream handshake; valid/data registered
//   occupancy       : held entries (0..2), equals the FSM state encoding
//   stall_cnt       : saturating count of out_valid & !out_ready cycles
//   stall_clr       : synchronous clear of stall_cnt (beats increment)
module pipe_skid_stage
    import pipe_pkg::*;
#(
    parameter int PAYLOAD_W   = EX_MEM_W,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [PAYLOAD_W-1:0]   in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [PAYLOAD_W-1:0]   out_data,
    output logic [1:0]             occupancy,
    output logic [STALL_CNT_W-1:0] stall_cnt,
    input  logic                   stall_clr
);

    skid_state_t            r_state;
    skid_state_t            w_state_next;
    logic                   r_in_ready;
    logic                   r_out_valid;
    logic [PAYLOAD_W-1:0]   r_main;
    logic [PAYLOAD_W-1:0]   r_skid;
    logic [STALL_CNT_W-1:0] r_stall_cnt;

    logic w_xfer_in;
    logic w_xfer_out;
    logic w_load_main_in;
    logic w_load_main_skid;
    logic w_load_skid;

    assign w_xfer_in  = in_valid & r_in_ready;
    assign w_xfer_out = r_out_valid & out_ready;

    always_comb begin
        w_state_next     = r_state;
        w_load_main_in   = 1'b0;
        w_load_main_skid = 1'b0;
        w_load_skid      = 1'b0;
        if (flush) begin
            w_state_next = ST_EMPTY;
        end else begin
            unique case (r_state)
                ST_EMPTY: begin
                    if (w_xfer_in) begin
                        w_load_main_in = 1'b1;
                        w_state_next   = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (w_xfer_in && w_xfer_out) begin
                        w_load_main_in = 1'b1;
                    end else if (w_xfer_out) begin
                        w_state_next = ST_EMPTY;
                    end else if (w_xfer_in) begin
                        // Downstream stalled: park the new payload in skid.
                        w_load_skid  = 1'b1;
                        w_state_next = ST_TWO;
                    end
                end
                ST_TWO: begin
                    if (w_xfer_out) begin
                        w_load_main_skid = 1'b1;
                        w_state_next     = ST_ONE;
                    end
                end
                default: w_state_next = ST_EMPTY;
            endcase
        end
    end

    // Handshake outputs are registered from the next state, so out_ready
    // never reaches in_ready combinationally.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state     <= ST_EMPTY;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_main      <= '0;
            r_skid      <= '0;
        end else begin
            r_state     <= w_state_next;
            r_out_valid <= (w_state_next != ST_EMPTY);
            r_in_ready  <= (w_state_next != ST_TWO);
            if (w_load_main_in) begin
                r_main <= in_data;
            end else if (w_load_main_skid) begin
                r_main <= r_skid;
            end
            if (w_load_skid) begin
                r_skid <= in_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_stall_cnt <= '0;
        end else if (stall_clr) begin
            r_stall_cnt <= '0;
        end else if (r_out_valid && !out_ready && !flush && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_main;
    assign occupancy = r_state;
    assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_pipe_skid_stage.sv
// tb_pipe_skid_stage -- directed self-checking bench for pipe_skid_stage.
// Accepted payloads are pushed to a scoreboard queue and popped/compared as
// the stage delivers them; occupancy/handshake/stall counter are checked
// against a small occupancy model every cycle.
module tb_pipe_skid_stage;
    import pipe_pkg::*;

    localparam int PW = EX_MEM_W;
    localparam int SW = 4;

    logic          clk = 1'b0;
    logic          resetn, flush, in_valid, out_ready, stall_clr;
    logic          in_ready, out_valid;
    logic [PW-1:0] in_data, out_data;
    logic [1:0]    occupancy;
    logic [SW-1:0] stall_cnt;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [PW-1:0] sb_q[$];
    int            exp_occ   = 0;
    int            exp_stall = 0;

    always #5 clk = ~clk;

    pipe_skid_stage #(
        .PAYLOAD_W   (PW),
        .STALL_CNT_W (SW)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .occupancy (occupancy),
        .stall_cnt (stall_cnt),
        .stall_clr (stall_clr)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_state();
        chk("occupancy", 128'(occupancy), 128'(exp_occ));
        chk("out_valid", 128'(out_valid), 128'(exp_occ != 0));
        chk("in_ready",  128'(in_ready),  128'(exp_occ != 2));
        chk("stall_cnt", 128'(stall_cnt), 128'(exp_stall));
    endtask

    // One clock cycle of stimulus; called just after a rising edge.
    task automatic step(input logic iv, input logic [PW-1:0] d, input logic ordy,
                        input logic fl, input logic clr);
        logic acc, fire;
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
        stall_clr = clr;
        resetn    = 1'b1;
        #1;
        acc  = iv && (exp_occ != 2);
        fire = (exp_occ != 0) && ordy;
        // Held payload must be the oldest outstanding one, stalled or not.
        if (exp_occ != 0) begin
            if (sb_q.size() != 0) begin
                chk("out_data", 128'(out_data), 128'(sb_q[0]));
            end else begin
                checks++;
                errors++;
                $error("FAIL scoreboard_empty observed=%0d expected=0", exp_occ);
            end
        end
        if (clr) exp_stall = 0;
        else if (exp_occ != 0 && !ordy && !fl && exp_stall != 15) exp_stall++;
        if (fl) begin
            sb_q.delete();
            exp_occ = 0;
        end else begin
            if (fire && sb_q.size() != 0) void'(sb_q.pop_front());
            if (acc) sb_q.push_back(d);
            exp_occ = exp_occ + int'(acc) - int'(fire);
        end
        $display("cyc %0d in_v=%0b d=%0h out_r=%0b fl=%0b clr=%0b acc=%0b out=%0b",
                 cyc, iv, d, ordy, fl, clr, acc, fire);
        @(posedge clk);
        #1;
        cyc++;
        chk_state();
    endtask

    // Reset cycle with flush and an upstream payload active to show override.
    task automatic reset_cycle();
        resetn    = 1'b0;
        in_valid  = 1'b1;
        in_data   = PW'(16'hDEAD);
        flush     = 1'b1;
        out_ready = 1'b1;
        stall_clr = 1'b0;
        $display("cyc %0d reset", cyc);
        @(posedge clk);
        #1;
        cyc++;
        sb_q.delete();
        exp_occ   = 0;
        exp_stall = 0;
        chk("rst_out_data", 128'(out_data), 128'(0));
        chk_state();
    endtask

    initial begin
        resetn = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        stall_clr = 1'b0; in_data = '0;
        @(posedge clk);
        #1;
        reset_cycle();

        // Streaming 1..8 at full rate, then drain.
        for (int i = 1; i <= 8; i++) step(1'b1, PW'(i), 1'b1, 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0, 1'b0);

        // Backpressure: A, B with out_ready low; stall count 1,2,3.
        step(1'b1, PW'(8'hA), 1'b0, 1'b0, 1'b0);
        step(1'b1, PW'(8'hB), 1'b0, 1'b0, 1'b0);
        step(1'b1, PW'(8'hEE), 1'b0, 1'b0, 1'b0); // refused: in_ready=0
        step(1'b0, '0, 1'b0, 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0, 1'b1);

        // ONE with simultaneous in/out, then ONE -> TWO -> drain one.
        step(1'b1, PW'(8'h21), 1'b1, 1'b0, 1'b0);
        step(1'b1, PW'(8'h22), 1'b1, 1'b0, 1'b0);
        step(1'b1, PW'(8'h23), 1'b0, 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0, 1'b0);

        // Flush in TWO with a payload offered: 0xC must vanish.
        step(1'b1, PW'(8'h11), 1'b0, 1'b0, 1'b0);
        step(1'b1, PW'(8'h12), 1'b0, 1'b0, 1'b0);
        step(1'b1, PW'(8'hC),  1'b0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0, 1'b0);
        step(1'b1, PW'(8'h13), 1'b1, 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0, 1'b1);

        // Saturation: 20 stall cycles on a 4-bit counter, then clear+stall.
        step(1'b1, PW'(8'h31), 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 19; i++) step(1'b0, '0, 1'b0, 1'b0, 1'b0);
        chk("stall_sat", 128'(stall_cnt), 128'(15));
        step(1'b0, '0, 1'b0, 1'b0, 1'b1);
        step(1'b0, '0, 1'b1, 1'b0, 1'b0);

        // Mid-operation reset in TWO, then a single payload afterwards.
        step(1'b1, PW'(8'h41), 1'b0, 1'b0, 1'b0);
        step(1'b1, PW'(8'h42), 1'b0, 1'b0, 1'b0);
        reset_cycle();
        step(1'b1, PW'(8'h55), 1'b0, 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0, 1'b0);
        chk("sb_drained", 128'(sb_q.size()), 128'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
